ysyx_22040088_idex_fwd: RTL
===========================

YSYX_22040088_IDEX_FWD -- requirements
Module: ysyx_22040088_idex_fwd

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/PC width.
REQ-002 SHALL have parameter NFWD, default 3, forwarding source count; index 0 = youngest (EX), rising index = older.
REQ-003 SHALL have parameter CTRL_W, default 32, opaque decoded-control bundle width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1: decoded-instruction handshake.
REQ-007 SHALL have ports in_pc input XLEN, in_ctrl input CTRL_W, in_rd input 5, in_we input 1: payload passed through.
REQ-008 SHALL have ports in_rs1/in_rs2 input 5 and in_re1/in_re2 input 1: source indices and read enables.
REQ-009 SHALL have ports rf_rdata1/rf_rdata2  input  XLEN  combinational regfile read data for in_rs1/in_rs2.
REQ-010 SHALL have ports fwd_we input NFWD, fwd_load input NFWD (result not yet available), fwd_waddr input 5*NFWD, fwd_data input XLEN*NFWD; slice i belongs to source i.
REQ-011 SHALL have port flush  input  1  kill held and incoming instruction.
REQ-012 SHALL have ports out_valid output 1 and out_ready input 1: EX-side handshake.
REQ-013 SHALL have ports out_pc XLEN, out_src1 XLEN, out_src2 XLEN, out_rd 5, out_we 1, out_ctrl CTRL_W, all outputs, registered.
REQ-014 SHALL have port stall_cnt  output  32  count of load-use stall cycles.

Function
REQ-015 Operand k SHALL resolve to 0 when in_rsk==0 or in_rek==0.
REQ-016 Otherwise SHALL select the lowest index i with fwd_we[i]=1 and fwd_waddr[i]==in_rsk; a match SHALL yield fwd_data[i] when fwd_load[i]=0.
REQ-017 A match on an older index SHALL be ignored when a younger index also matches (youngest wins, even if the younger is a load).
REQ-018 No match SHALL yield rf_rdatak.
REQ-019 hazard SHALL be 1 when in_valid=1 and either operand's selected match has fwd_load[i]=1.
REQ-020 in_ready SHALL equal flush OR (!hazard AND (!out_valid OR out_ready)), combinationally.
REQ-021 On a clock edge with flush=1: out_valid<=0, incoming instruction discarded, payload registers unchanged.
REQ-022 Else, when !out_valid OR out_ready: out_valid<=in_valid AND !hazard; payload and resolved operands load only when in_valid AND !hazard.
REQ-023 Else (out_valid=1, out_ready=0): all output registers SHALL hold.
REQ-024 A hazard with out_ready=1 SHALL insert a bubble (out_valid=0 next cycle), never duplicate the prior instruction.
REQ-025 Latency SHALL be exactly one cycle from accept (in_valid AND in_ready AND !flush) to out_valid=1.
REQ-026 stall_cnt SHALL increment by 1 each cycle with hazard=1 and flush=0, saturating at 32'hFFFF_FFFF.
REQ-027 No operand path SHALL depend on registered state; forwarding is fully combinational into the output register.

Reset
REQ-028 rst=1 SHALL immediately clear out_valid, out_pc, out_src1, out_src2, out_rd, out_we, out_ctrl and stall_cnt to 0, independent of clk.
REQ-029 in_ready SHALL evaluate per REQ-020 during reset; no accept SHALL register while rst=1.
REQ-030 Reset asserted mid-stall or mid-backpressure SHALL drop the held instruction with no output valid on release.

Verification
REQ-031 No match: rs1=5, rf_rdata1=64'h11, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_src1=64'h11.
REQ-032 Priority: rs2=7, fwd 0 and 2 both write x7 with data 64'hA / 64'hC, loads=0 -> out_src2=64'hA; drop source 0 -> 64'hC.
REQ-033 Load-use: fwd_load[0]=1 with waddr=rs1=3 for 2 cycles -> in_ready=0, out_valid=0 both cycles, stall_cnt=2; fwd_load cleared with data 64'h55 -> out_src1=64'h55 one cycle later.
REQ-034 x0: rs1=0, fwd_we[0]=1, waddr=0, fwd_load[0]=1 -> no hazard, out_src1=0.
REQ-035 Backpressure and flush: out_valid=1, out_ready=0 for 3 cycles -> outputs stable, in_ready=0; assert flush one cycle -> out_valid=0, in_ready=1, stall_cnt unchanged.
REQ-036 Async reset: assert rst between edges with out_valid=1, stall_cnt=9 -> out_valid=0, stall_cnt=0 before the next edge.

Source files
------------

// File: rtl/ysyx_22040088_idex_fwd.sv
// ysyx_22040088_idex_fwd: ID/EX pipeline register with operand forwarding and load-use stall
//   in_*      decoded instruction (valid/ready handshake, payload, source indices, read enables)
//   rf_rdata* combinational register-file read data for in_rs1/in_rs2
//   fwd_*     NFWD forwarding sources, slice 0 youngest; fwd_load marks results not yet available
//   flush     kills held and incoming instruction
//   out_*     registered EX-side instruction (valid/ready handshake)
//   stall_cnt saturating count of load-use stall cycles
module ysyx_22040088_idex_fwd #(
  parameter int XLEN = 64,
  parameter int NFWD = 3,
  parameter int CTRL_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [4:0]           in_rd,
  input  logic                 in_we,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic                 in_re1,
  input  logic                 in_re2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD-1:0]      fwd_load,
  input  logic [5*NFWD-1:0]    fwd_waddr,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_src1,
  output logic [XLEN-1:0]      out_src2,
  output logic [4:0]           out_rd,
  output logic                 out_we,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [31:0]          stall_cnt
);
  // Returns {pending_load, value}; scanning oldest to youngest lets the youngest match win.
  function automatic logic [XLEN:0] resolve(input logic [4:0] rs, input logic re, input logic [XLEN-1:0] rf);
    logic [XLEN:0] r;
    r = {1'b0, rf};
    for (int i = NFWD - 1; i >= 0; i--)
      if (fwd_we[i] && fwd_waddr[i*5 +: 5] == rs) r = {fwd_load[i], fwd_data[i*XLEN +: XLEN]};
    return (rs == 5'd0 || !re) ? '0 : r;
  endfunction
  logic [XLEN-1:0] op1, op2;
  logic ld1, ld2, hazard, take, advance;
  assign {ld1, op1} = resolve(in_rs1, in_re1, rf_rdata1);
  assign {ld2, op2} = resolve(in_rs2, in_re2, rf_rdata2);
  assign hazard = in_valid && (ld1 || ld2);
  assign advance = !out_valid || out_ready;
  assign take = in_valid && !hazard;
  assign in_ready = flush || (!hazard && advance);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_src1  <= '0;
      out_src2  <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
      out_ctrl  <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) out_valid <= 1'b0;
      else if (advance) begin
        out_valid <= take;
        if (take) begin
          out_pc   <= in_pc;
          out_src1 <= op1;
          out_src2 <= op2;
          out_rd   <= in_rd;
          out_we   <= in_we;
          out_ctrl <= in_ctrl;
        end
      end
      if (hazard && !flush && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule
